// File: rtl/alu_operand_stage_if.sv
// rtl/alu_operand_stage_if.sv - instruction handshake and ALU operand/result bus for alu_operand_stage
interface alu_operand_stage_if #(
  parameter int DW = 8
);
  logic          instr_valid;
  logic          instr_ready;
  logic [15:0]   instr;
  logic [DW-1:0] imm;
  logic [DW-1:0] alu_in1;
  logic [DW-1:0] alu_in2;
  logic [3:0]    alu_mode;
  logic [DW-1:0] alu_out;
  logic          alu_zero;
  logic          alu_carry;

  // The issue stage itself
  modport slave (
    input  instr_valid, instr, imm, alu_out, alu_zero, alu_carry,
    output instr_ready, alu_in1, alu_in2, alu_mode
  );

  // Instruction source plus the combinational ALU
  modport master (
    output instr_valid, instr, imm, alu_out, alu_zero, alu_carry,
    input  instr_ready, alu_in1, alu_in2, alu_mode
  );
endinterface

// File: rtl/alu_operand_stage.sv
// rtl/alu_operand_stage.sv - issue/writeback stage around an 8-bit ALU; optional debug RF read port under DBG_RF_PORT_EN
module alu_operand_stage #(
  parameter int NREG = 8,
  parameter int DW   = 8
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  alu_operand_stage_if.slave    bus,
  output logic                  o_done,
  output logic                  o_err,
  output logic                  o_flag_z,
  output logic                  o_flag_c
`ifdef DBG_RF_PORT_EN
  ,
  input  logic [2:0]            i_dbg_addr,
  output logic [DW-1:0]         o_dbg_data
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_WB} state_t;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_CMP = 4'd2;
  localparam logic [3:0] OP_AND = 4'd3;
  localparam logic [3:0] OP_OR  = 4'd4;
  localparam logic [3:0] OP_XOR = 4'd5;

  state_t        r_state;
  logic [DW-1:0] r_rf [NREG];
  logic [2:0]    r_rd;
  logic [3:0]    r_mode;
  logic [DW-1:0] r_in1;
  logic [DW-1:0] r_in2;
  logic [DW-1:0] r_res;
  logic          r_cz;
  logic          r_cc;
  logic          r_ready;
  logic          r_done;
  logic          r_err;
  logic          r_fz;
  logic          r_fc;

  logic [3:0]    w_op;
  logic [2:0]    w_rd;
  logic [2:0]    w_rs1;
  logic [2:0]    w_rs2;
  logic          w_use_imm;
  logic [DW-1:0] w_op_a;
  logic [DW-1:0] w_op_b;
  logic          w_illegal;
  logic          w_unused;

  // Decode the presented instruction and read both operands; R0 is hard zero
  always_comb begin
    w_op      = bus.instr[15:12];
    w_rd      = bus.instr[11:9];
    w_rs1     = bus.instr[8:6];
    w_rs2     = bus.instr[5:3];
    w_use_imm = bus.instr[0];
    w_op_a    = (w_rs1 == 3'd0) ? '0 : r_rf[w_rs1];
    w_op_b    = w_use_imm ? bus.imm : ((w_rs2 == 3'd0) ? '0 : r_rf[w_rs2]);
    w_illegal = (r_mode > OP_XOR);
    w_unused  = ^bus.instr[2:1];
  end

  // IDLE -> EXEC -> WB sequencer; ALU drive, result capture and writeback are all registered
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < NREG; i++) r_rf[i] <= '0;
      r_state <= S_IDLE;
      r_rd    <= '0;
      r_mode  <= '0;
      r_in1   <= '0;
      r_in2   <= '0;
      r_res   <= '0;
      r_cz    <= 1'b0;
      r_cc    <= 1'b0;
      r_ready <= 1'b1;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
      r_fz    <= 1'b0;
      r_fc    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.instr_valid) begin
            r_rd    <= w_rd;
            r_mode  <= w_op;
            r_in1   <= w_op_a;
            r_in2   <= w_op_b;
            r_ready <= 1'b0;
            r_state <= S_EXEC;
          end
        end
        S_EXEC: begin
          r_res   <= bus.alu_out;
          r_cz    <= bus.alu_zero;
          r_cc    <= bus.alu_carry;
          r_done  <= 1'b1;
          r_err   <= w_illegal;
          r_state <= S_WB;
        end
        S_WB: begin
          case (r_mode)
            OP_ADD, OP_SUB: begin
              if (r_rd != 3'd0) r_rf[r_rd] <= r_res;
              r_fz <= (r_res == '0);
              r_fc <= r_cc;
            end
            OP_CMP: begin
              r_fz <= r_cz;
              r_fc <= r_cc;
            end
            OP_AND, OP_OR, OP_XOR: begin
              if (r_rd != 3'd0) r_rf[r_rd] <= r_res;
              r_fz <= (r_res == '0);
              r_fc <= 1'b0;
            end
            default: ;
          endcase
          r_ready <= 1'b1;
          r_state <= S_IDLE;
        end
        default: begin
          r_ready <= 1'b1;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.instr_ready = r_ready;
  assign bus.alu_in1     = r_in1;
  assign bus.alu_in2     = r_in2;
  assign bus.alu_mode    = r_mode;
  assign o_done          = r_done;
  assign o_err           = r_err;
  assign o_flag_z        = r_fz;
  assign o_flag_c        = r_fc;

`ifdef DBG_RF_PORT_EN
  assign o_dbg_data = (i_dbg_addr == 3'd0) ? '0 : r_rf[i_dbg_addr];
`endif

endmodule

// File: tb/tb_alu_operand_stage.sv
// tb/tb_alu_operand_stage.sv - self-checking bench for alu_operand_stage with ALU model and reference model
module tb_alu_operand_stage;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic done, err, flag_z, flag_c;
  int   checks = 0;
  int   failures = 0;

  alu_operand_stage_if #(.DW(8)) bus ();

`ifdef DBG_RF_PORT_EN
  logic [2:0] dbg_addr = 3'd0;
  logic [7:0] dbg_data;
`endif

  alu_operand_stage #(.NREG(8), .DW(8)) dut (
    .i_clk    (clk),
    .i_rst    (rst),
    .bus      (bus),
    .o_done   (done),
    .o_err    (err),
    .o_flag_z (flag_z),
    .o_flag_c (flag_c)
`ifdef DBG_RF_PORT_EN
    ,
    .i_dbg_addr (dbg_addr),
    .o_dbg_data (dbg_data)
`endif
  );

  always #5 clk = ~clk;

  // Combinational 8-bit ALU: carry is carry-out for ADD, borrow for SUB/CMP
  logic [8:0] alu_t;
  always_comb begin
    alu_t = '0;
    case (bus.alu_mode)
      4'd0:       alu_t = {1'b0, bus.alu_in1} + {1'b0, bus.alu_in2};
      4'd1, 4'd2: alu_t = {1'b0, bus.alu_in1} - {1'b0, bus.alu_in2};
      4'd3:       alu_t = {1'b0, bus.alu_in1 & bus.alu_in2};
      4'd4:       alu_t = {1'b0, bus.alu_in1 | bus.alu_in2};
      4'd5:       alu_t = {1'b0, bus.alu_in1 ^ bus.alu_in2};
      default:    alu_t = '0;
    endcase
    bus.alu_out   = alu_t[7:0];
    bus.alu_carry = alu_t[8];
    bus.alu_zero  = (alu_t[7:0] == 8'h00);
  end

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] enc(input logic [3:0] op, input logic [2:0] rd,
                                      input logic [2:0] rs1, input logic [2:0] rs2, input logic ui);
    return {op, rd, rs1, rs2, 2'b00, ui};
  endfunction

  // Reference model: architectural state plus cycles-since-accept (0 idle, 1 exec, 2 writeback)
  logic [7:0] m_rf [8];
  logic       m_z, m_c, m_live = 1'b0;
  logic [7:0] m_in1, m_in2;
  logic [3:0] m_op;
  logic [2:0] m_rd;
  int         m_cnt = 0;

  always @(posedge clk) begin
    logic [8:0] sum;
    logic [7:0] res;
    if (rst) begin
      for (int i = 0; i < 8; i++) m_rf[i] = 8'h00;
      m_z = 0; m_c = 0; m_in1 = 0; m_in2 = 0; m_op = 0; m_rd = 0; m_cnt = 0; m_live = 1;
    end else if (m_cnt == 0) begin
      if (bus.instr_valid) begin
        m_op  = bus.instr[15:12];
        m_rd  = bus.instr[11:9];
        m_in1 = m_rf[bus.instr[8:6]];
        m_in2 = bus.instr[0] ? bus.imm : m_rf[bus.instr[5:3]];
        m_cnt = 1;
      end
    end else if (m_cnt == 1) begin
      m_cnt = 2;
    end else begin
      sum = {1'b0, m_in1} + {1'b0, m_in2};
      res = 8'h00;
      case (m_op)
        4'd0: begin res = sum[7:0];       m_c = sum[8];        m_z = (res == 0); end
        4'd1: begin res = m_in1 - m_in2;  m_c = (m_in1 < m_in2); m_z = (res == 0); end
        4'd2: begin                       m_c = (m_in1 < m_in2); m_z = (m_in1 == m_in2); end
        4'd3: begin res = m_in1 & m_in2;  m_c = 0;             m_z = (res == 0); end
        4'd4: begin res = m_in1 | m_in2;  m_c = 0;             m_z = (res == 0); end
        4'd5: begin res = m_in1 ^ m_in2;  m_c = 0;             m_z = (res == 0); end
        default: ;
      endcase
      if (m_op <= 4'd5 && m_op != 4'd2 && m_rd != 0) m_rf[m_rd] = res;
      m_cnt = 0;
    end
  end

  // Every-cycle comparison of all DUT outputs against the model
  always @(negedge clk) begin
    if (m_live) begin
      chk("ready",    bus.instr_ready, (m_cnt == 0));
      chk("done",     done,            (m_cnt == 2));
      chk("err",      err,             (m_cnt == 2) && (m_op > 4'd5));
      chk("flag_z",   flag_z,          m_z);
      chk("flag_c",   flag_c,          m_c);
      chk("alu_in1",  bus.alu_in1,     m_in1);
      chk("alu_in2",  bus.alu_in2,     m_in2);
      chk("alu_mode", bus.alu_mode,    m_op);
`ifdef DBG_RF_PORT_EN
      chk("dbg_data", dbg_data,        m_rf[dbg_addr]);
      dbg_addr = 3'($urandom_range(0, 7));
`endif
    end
  end

  // Present one instruction, wait for its accept edge, return in its EXEC cycle
  task automatic issue(input logic [15:0] ins, input logic [7:0] im);
    int n = 0;
    @(negedge clk);
    bus.instr_valid = 1'b1;
    bus.instr       = ins;
    bus.imm         = im;
    while (!bus.instr_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) begin
      checks++;
      failures++;
      $display("FAIL issue_timeout actual=ready_low required=ready_high");
    end
    @(negedge clk);
    bus.instr_valid = 1'b0;
  endtask

  initial begin
    bus.instr_valid = 1'b0;
    bus.instr       = '0;
    bus.imm         = '0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // 1: reset mid-EXEC of ADD r1,r0,#33 drops the write
    issue(enc(4'd0, 3'd1, 3'd0, 3'd0, 1'b1), 8'h33);
    chk("t1_exec_in2", bus.alu_in2, 16'h33);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("t1_ready", bus.instr_ready, 16'h1);
    chk("t1_fz", flag_z, 16'h0);
    chk("t1_fc", flag_c, 16'h0);
    issue(enc(4'd4, 3'd5, 3'd1, 3'd0, 1'b1), 8'h00);
    chk("t1_r1_zero", bus.alu_in1, 16'h00);

    // 2: ADD r1,r0,#0F ; ADD r2,r1,#F1 -> 0x00, carry and zero
    issue(enc(4'd0, 3'd1, 3'd0, 3'd0, 1'b1), 8'h0F);
    issue(enc(4'd0, 3'd2, 3'd1, 3'd0, 1'b1), 8'hF1);
    chk("t2_in1", bus.alu_in1, 16'h0F);
    @(negedge clk);
    chk("t2_done", done, 16'h1);
    @(negedge clk);
    chk("t2_fc", flag_c, 16'h1);
    chk("t2_fz", flag_z, 16'h1);

    // 3: SUB r3,r1,r2 with 5 and 7 -> 0xFE with borrow
    issue(enc(4'd0, 3'd1, 3'd0, 3'd0, 1'b1), 8'h05);
    issue(enc(4'd0, 3'd2, 3'd0, 3'd0, 1'b1), 8'h07);
    issue(enc(4'd1, 3'd3, 3'd1, 3'd2, 1'b0), 8'h00);
    chk("t3_in1", bus.alu_in1, 16'h05);
    chk("t3_in2", bus.alu_in2, 16'h07);
    repeat (2) @(negedge clk);
    chk("t3_fc", flag_c, 16'h1);
    chk("t3_fz", flag_z, 16'h0);

    // 4: CMP r1,r1 sets z, clears c, writes nothing; then CMP 3 vs 9
    issue(enc(4'd2, 3'd1, 3'd1, 3'd1, 1'b0), 8'h00);
    repeat (2) @(negedge clk);
    chk("t4_fz", flag_z, 16'h1);
    chk("t4_fc", flag_c, 16'h0);
    issue(enc(4'd4, 3'd6, 3'd3, 3'd1, 1'b0), 8'h00);
    chk("t4_r3", bus.alu_in1, 16'hFE);
    chk("t4_r1_kept", bus.alu_in2, 16'h05);
    issue(enc(4'd0, 3'd1, 3'd0, 3'd0, 1'b1), 8'h03);
    issue(enc(4'd2, 3'd0, 3'd1, 3'd0, 1'b1), 8'h09);
    repeat (2) @(negedge clk);
    chk("t4b_fz", flag_z, 16'h0);
    chk("t4b_fc", flag_c, 16'h1);

    // 5: XOR r4,r1,r1 with 0xA5 -> zero; AND into r0 is dropped
    issue(enc(4'd0, 3'd1, 3'd0, 3'd0, 1'b1), 8'hA5);
    issue(enc(4'd5, 3'd4, 3'd1, 3'd1, 1'b0), 8'h00);
    repeat (2) @(negedge clk);
    chk("t5_fz", flag_z, 16'h1);
    chk("t5_fc", flag_c, 16'h0);
    issue(enc(4'd3, 3'd0, 3'd1, 3'd0, 1'b1), 8'hFF);
    issue(enc(4'd0, 3'd7, 3'd0, 3'd4, 1'b0), 8'h00);
    chk("t5_r0", bus.alu_in1, 16'h00);
    chk("t5_r4", bus.alu_in2, 16'h00);

    // 6: illegal op 0xE then ADD with instr_valid held high throughout
    issue(enc(4'd1, 3'd2, 3'd0, 3'd0, 1'b1), 8'h01);
    repeat (2) @(negedge clk);
    bus.instr_valid = 1'b1;
    bus.instr       = enc(4'hE, 3'd2, 3'd2, 3'd0, 1'b1);
    bus.imm         = 8'h00;
    @(negedge clk);
    bus.instr       = enc(4'd0, 3'd3, 3'd2, 3'd0, 1'b1);
    bus.imm         = 8'h01;
    @(negedge clk);
    chk("t6_err", err, 16'h1);
    chk("t6_ready_low", bus.instr_ready, 16'h0);
    @(negedge clk);
    chk("t6_fc_kept", flag_c, 16'h1);
    chk("t6_fz_kept", flag_z, 16'h0);
    @(negedge clk);
    chk("t6_r2_kept", bus.alu_in1, 16'hFF);
    chk("t6_imm", bus.alu_in2, 16'h01);
    bus.instr_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("t6_fz", flag_z, 16'h1);
    chk("t6_fc", flag_c, 16'h1);

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
